alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one 4-bit ALU datapath between two requesters, each with a valid/ready request channel.
- Round-robin arbiter, 3-state FSM sequencer and registered response channel tagged with the requester ID.
- Sits between on-chip command sources and the ALU compute core. Owns operand/opcode capture, result/flag registration and response backpressure.

Parameters:
- CNT_W, 8, width of the optional grant/div-by-zero statistics counters (used only with ALU_STATS_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a command
- req0_ready  out  1  requester 0 command accepted this cycle
- req0_op  in  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT
- req0_a  in  4  operand a
- req0_b  in  4  operand b
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same widths and meaning, requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester that issued the command
- rsp_result  out  8  ALU result
- rsp_carry  out  1  carry / not-borrow flag
- rsp_ovf  out  1  signed overflow flag
- busy  out  1  FSM not in IDLE
- stat_gnt0, stat_gnt1, stat_divz  out  CNT_W each  present only with ALU_STATS_EN

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE.
  - rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, busy all 0.
  - Round-robin pointer last_gnt=1, so req0 wins the first contention.
  - Reset mid-operation discards the in-flight command; no response is produced for it.
- FSM states:
  - IDLE:
    - If any reqN_valid, grant per round-robin.
    - reqN_ready=1 (combinational) for the winner only. Capture op/a/b/id. Go to EXEC.
    - No valid request: stay in IDLE.
  - EXEC: compute on the captured operands; register result and flags. Go to RESP.
  - RESP:
    - rsp_valid=1; all rsp_* outputs held stable.
    - rsp_valid && rsp_ready: update last_gnt=rsp_id, go to IDLE.
- Ready rules:
  - Both ready signals are 0 outside IDLE.
  - Never both 1 in the same cycle.
  - Ready never depends on rsp_ready.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester != last_gnt wins.
- Timing:
  - Latency from accept to rsp_valid is 2 cycles.
  - Minimum issue interval is 3 cycles.
  - Each extra cycle rsp_ready is low adds 1 cycle.
- Arithmetic (a, b unsigned 4-bit):
  - ADD:
    - result = {4'b0, (a+b)[3:0]}; carry = (a+b)[4].
    - ovf = (a3 & b3 & ~s3) | (~a3 & ~b3 & s3).
  - SUB:
    - result = {4'b0, (a-b)[3:0]}; carry = 1 when a >= b.
    - ovf = (a3 & ~b3 & ~d3) | (~a3 & b3 & d3).
  - MUL: result = a*b (8-bit).
  - DIV:
    - result[7:4] = a % b; result[3:0] = a / b.
    - b == 0 gives result 0x00.
  - AND/OR/XOR: result = {4'b0, a op b}.
  - NOT: result = {4'b0, ~a}.
  - carry and ovf are 0 for all ops other than ADD and SUB.

Optional Feature:
- Macro ALU_STATS_EN.
- Defined:
  - stat_gnt0 and stat_gnt1 increment on each accepted command of their requester.
  - stat_divz increments on each accepted DIV with b == 0.
  - All three saturate at all-ones and reset to 0.
- Undefined: the counters and stat_* ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams OP_ADD..OP_NOT
  - FSM state enum (IDLE, EXEC, RESP)
  - the 8-bit result and 4-bit operand widths
- One sub-module: alu4_core, the purely combinational op/a/b -> result/carry/ovf function, instantiated in EXEC.
- Arbiter and FSM stay in alu_rr_scheduler.

Test Plan:
- Single ADD:
  - Stimulus: req0 op=0, a=7, b=9, rsp_ready=1.
  - Response: req0_ready pulses one cycle; rsp_valid 2 cycles later with result=0x00, carry=1, ovf=0, rsp_id=0.
- Contention:
  - Stimulus: both valid from reset. req0 SUB a=3, b=5; req1 MUL a=15, b=15.
  - Response: first rsp_id=0, result=0x0E, carry=0, ovf=0. Then rsp_id=1, result=0xE1.
  - Then with both valid again, req0 is granted.
- DIV:
  - Stimulus: a=13, b=4, then a=9, b=0.
  - Response: results 0x13 and 0x00.
  - With ALU_STATS_EN: stat_divz=1.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles during RESP.
  - Response: rsp_* outputs stable; both ready signals 0; busy=1. Completes on the first rsp_ready=1.
- Reset mid-EXEC:
  - Stimulus: assert rst_n=0 while in EXEC.
  - Response: immediately rsp_valid=0, busy=0. No response for the aborted command; next grant goes to req0.
- ADD overflow / NOT:
  - ADD a=4, b=4 gives result 0x08, ovf=1, carry=0.
  - NOT a=0x5 gives result 0x0A, carry=0, ovf=0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the ALU round-robin scheduler and its
// combinational ALU core.
//   - operand / result widths
//   - opcode encodings OP_ADD .. OP_NOT
//   - sequencer state encoding (IDLE, EXEC, RESP)
package alu_pkg;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu4_core.sv
// alu4_core: purely combinational 4-bit ALU.
// Ports:
//   op     in  3  opcode (alu_pkg OP_*)
//   a, b   in  4  unsigned operands
//   result out 8  ALU result
//   carry  out 1  ADD carry-out / SUB not-borrow (a >= b), else 0
//   ovf    out 1  ADD/SUB signed overflow, else 0
module alu4_core
    import alu_pkg::*;
(
    input  logic [2:0]        op,
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    output logic [RES_W-1:0]  result,
    output logic              carry,
    output logic              ovf
);

    localparam int PAD_W = RES_W - OPND_W;

    logic [OPND_W:0]   sum;
    logic [OPND_W-1:0] diff;
    logic [RES_W-1:0]  prod;
    logic [OPND_W-1:0] quot;
    logic [OPND_W-1:0] rem;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = a - b;
    assign prod = {{PAD_W{1'b0}}, a} * {{PAD_W{1'b0}}, b};
    // Divide by zero is masked below; the quotient/remainder of b == 0 never
    // reaches the result.
    assign quot = a / b;
    assign rem  = a % b;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = {{PAD_W{1'b0}}, sum[OPND_W-1:0]};
                carry  = sum[OPND_W];
                ovf    = (a[3] & b[3] & ~sum[3]) | (~a[3] & ~b[3] & sum[3]);
            end
            OP_SUB: begin
                result = {{PAD_W{1'b0}}, diff};
                carry  = (a >= b);
                ovf    = (a[3] & ~b[3] & ~diff[3]) | (~a[3] & b[3] & diff[3]);
            end
            OP_MUL: result = prod;
            OP_DIV: begin
                if (b != '0) begin
                    result = {rem, quot};
                end
            end
            OP_AND: result = {{PAD_W{1'b0}}, a & b};
            OP_OR:  result = {{PAD_W{1'b0}}, a | b};
            OP_XOR: result = {{PAD_W{1'b0}}, a ^ b};
            OP_NOT: result = {{PAD_W{1'b0}}, ~a};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: shares one 4-bit ALU between two requesters.
// A round-robin arbiter picks a requester in IDLE, the command is captured,
// computed in EXEC and presented on a registered, ID-tagged response channel
// in RESP until the consumer takes it.
//
// Handshake rule (all channels): a transfer happens on a rising clk edge where
// valid && ready are both 1. The source holds valid and payload stable until
// that edge; reqN_ready is combinational from state, valids and the
// round-robin pointer only (never from rsp_ready).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   reqN_valid/ready/op/a/b (N=0,1) command channels
//   rsp_valid/ready                 response handshake
//   rsp_id                          requester that issued the command
//   rsp_result/carry/ovf            registered ALU outputs
//   busy                            sequencer not in IDLE
//   fsm_state                       sequencer state, for observation
//   stat_gnt0/gnt1/divz             saturating counters, only when the
//                                   ALU_STATS_EN macro is defined
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_op,
    input  logic [OPND_W-1:0] req0_a,
    input  logic [OPND_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [2:0]        req1_op,
    input  logic [OPND_W-1:0] req1_a,
    input  logic [OPND_W-1:0] req1_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [RES_W-1:0]  rsp_result,
    output logic              rsp_carry,
    output logic              rsp_ovf,
    output logic              busy,
    output state_e            fsm_state
`ifdef ALU_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_gnt0,
    output logic [CNT_W-1:0]  stat_gnt1,
    output logic [CNT_W-1:0]  stat_divz
`endif
);

    state_e            state;
    state_e            state_nxt;
    logic              last_gnt;
    logic              gnt0;
    logic              gnt1;
    logic              accept;

    logic              sel_id;
    logic [2:0]        sel_op;
    logic [OPND_W-1:0] sel_a;
    logic [OPND_W-1:0] sel_b;

    logic [2:0]        cap_op;
    logic [OPND_W-1:0] cap_a;
    logic [OPND_W-1:0] cap_b;
    logic              cap_id;

    logic [RES_W-1:0]  core_result;
    logic              core_carry;
    logic              core_ovf;

    // Round robin: a lone requester always wins; on contention the one that
    // was not served last wins. gnt0 and gnt1 are mutually exclusive.
    assign gnt0 = req0_valid && (!req1_valid || last_gnt);
    assign gnt1 = req1_valid && (!req0_valid || !last_gnt);

    assign sel_id = gnt1;
    assign sel_op = gnt1 ? req1_op : req0_op;
    assign sel_a  = gnt1 ? req1_a  : req0_a;
    assign sel_b  = gnt1 ? req1_b  : req0_b;

    assign accept    = req0_ready || req1_ready;
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy       = 1'b0;
                req0_ready = gnt0;
                req1_ready = gnt1;
                if (gnt0 || gnt1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_op <= '0;
            cap_a  <= '0;
            cap_b  <= '0;
            cap_id <= 1'b0;
        end else if (accept) begin
            cap_op <= sel_op;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_id <= sel_id;
        end
    end

    alu4_core u_core (
        .op     (cap_op),
        .a      (cap_a),
        .b      (cap_b),
        .result (core_result),
        .carry  (core_carry),
        .ovf    (core_ovf)
    );

    // Response registers are loaded only in EXEC, so they hold stable for the
    // whole RESP stall. The pointer moves when the response is consumed, which
    // means an aborted command never counts as served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
            last_gnt   <= 1'b1;
        end else begin
            if (state == EXEC) begin
                rsp_id     <= cap_id;
                rsp_result <= core_result;
                rsp_carry  <= core_carry;
                rsp_ovf    <= core_ovf;
            end
            if (rsp_valid && rsp_ready) begin
                last_gnt <= rsp_id;
            end
        end
    end

`ifdef ALU_STATS_EN
    logic divz_hit;
    assign divz_hit = accept && (sel_op == OP_DIV) && (sel_b == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
            stat_divz <= '0;
        end else begin
            if (req0_ready && (stat_gnt0 != '1)) begin
                stat_gnt0 <= stat_gnt0 + 1'b1;
            end
            if (req1_ready && (stat_gnt1 != '1)) begin
                stat_gnt1 <= stat_gnt1 + 1'b1;
            end
            if (divz_hit && (stat_divz != '1)) begin
                stat_divz <= stat_divz + 1'b1;
            end
        end
    end
`else
    // Counter width only matters when the statistics are built in.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: self-checking bench for alu_rr_scheduler.
// Table-driven vectors plus directed sequences for contention, latency,
// backpressure and reset during EXEC. Expected responses are queued when a
// command is accepted and compared when the response is consumed.
// Build with ALU_STATS_EN defined to also check the statistics counters.
module tb_alu_rr_scheduler;
    import alu_pkg::*;

    localparam int CNT_W = 8;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [2:0]  req0_op;
    logic [3:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready;
    logic [2:0]  req1_op;
    logic [3:0]  req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_carry, rsp_ovf, busy;
    state_e      fsm_state;
`ifdef ALU_STATS_EN
    logic [CNT_W-1:0] stat_gnt0, stat_gnt1, stat_divz;
`endif

    alu_rr_scheduler #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_carry  (rsp_carry),
        .rsp_ovf    (rsp_ovf),
        .busy       (busy),
        .fsm_state  (fsm_state)
`ifdef ALU_STATS_EN
        ,
        .stat_gnt0  (stat_gnt0),
        .stat_gnt1  (stat_gnt1),
        .stat_divz  (stat_divz)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [10:0] exp_q[$];   // {id, result[7:0], carry, ovf}
    int n_cmp = 0;
    int n_bad = 0;
    int exp_gnt0 = 0;
    int exp_gnt1 = 0;
    int exp_divz = 0;

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] res;
        logic       c;
        logic       o;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive point: 2 time units after the falling edge, well clear of posedge.
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic drive_req(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic clear_req(input logic id);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    function automatic logic ready_of(input logic id);
        return (id == 1'b0) ? req0_ready : req1_ready;
    endfunction

    task automatic note_accept(input logic id, input logic [2:0] op, input logic [3:0] b,
                               input logic [7:0] r, input logic c, input logic o);
        exp_q.push_back({id, r, c, o});
        if (id == 1'b0) exp_gnt0++;
        else            exp_gnt1++;
        if (op == OP_DIV && b == 4'd0) exp_divz++;
    endtask

    // Waits (bounded) for the requester's ready and books the expected result.
    task automatic await_accept(input logic id, input logic [2:0] op, input logic [3:0] b,
                                input logic [7:0] r, input logic c, input logic o);
        int n;
        n = 0;
        #1;
        while (!ready_of(id) && n < 20) begin
            tick();
            #1;
            n++;
        end
        if (ready_of(id)) begin
            note_accept(id, op, b, r, c, o);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: requester %0d got no ready within 20 cycles, expected a grant", id);
        end
    endtask

    task automatic issue(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] r, input logic c, input logic o);
        drive_req(id, op, a, b);
        await_accept(id, op, b, r, c, o);
        tick();
        clear_req(id);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Independent reference using signed integer range checks.
    function automatic logic [9:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int ia, ib, sa, sb, t;
        logic [7:0] r;
        logic c, o;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 8) ? ia - 16 : ia;
        sb = (ib >= 8) ? ib - 16 : ib;
        r = 8'h00; c = 1'b0; o = 1'b0;
        case (op)
            OP_ADD: begin
                t = ia + ib; r = 8'(t % 16); c = (t >= 16);
                o = ((sa + sb) > 7) || ((sa + sb) < -8);
            end
            OP_SUB: begin
                t = ia - ib; r = 8'((t + 16) % 16); c = (ia >= ib);
                o = ((sa - sb) > 7) || ((sa - sb) < -8);
            end
            OP_MUL: r = 8'(ia * ib);
            OP_DIV: if (ib != 0) r = 8'((ia % ib) * 16 + ia / ib);
            OP_AND: r = {4'h0, a & b};
            OP_OR:  r = {4'h0, a | b};
            OP_XOR: r = {4'h0, a ^ b};
            default: r = {4'h0, ~a};
        endcase
        return {r, c, o};
    endfunction

    // ---------------- response monitor ----------------
    // Samples just before the rising edge, so a seen handshake is the one that
    // edge will complete.
    initial begin
        logic [10:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n) begin
                check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL rsp_unexpected: got id=%0d result=0x%0h, expected no response",
                                 rsp_id, rsp_result);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_word", {21'd0, rsp_id, rsp_result, rsp_carry, rsp_ovf}, {21'd0, e});
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [9:0] m;
        logic       rid;
        logic [2:0] rop;
        logic [3:0] ra, rb;
        int         n;

        vecs[0]  = '{1'b0, OP_ADD, 4'd7,  4'd9,  8'h00, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, OP_ADD, 4'd4,  4'd4,  8'h08, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, OP_NOT, 4'h5,  4'd0,  8'h0A, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, OP_DIV, 4'd13, 4'd4,  8'h13, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, OP_DIV, 4'd9,  4'd0,  8'h00, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, OP_SUB, 4'd5,  4'd3,  8'h02, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, OP_SUB, 4'd8,  4'd1,  8'h07, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, OP_MUL, 4'd3,  4'd5,  8'h0F, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, OP_AND, 4'hC,  4'hA,  8'h08, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, OP_OR,  4'hC,  4'hA,  8'h0E, 1'b0, 1'b0};
        vecs[10] = '{1'b0, OP_XOR, 4'hC,  4'hA,  8'h06, 1'b0, 1'b0};
        vecs[11] = '{1'b1, OP_ADD, 4'hF,  4'h1,  8'h00, 1'b1, 1'b0};
        vecs[12] = '{1'b0, OP_SUB, 4'd0,  4'd1,  8'h0F, 1'b0, 1'b0};
        vecs[13] = '{1'b1, OP_ADD, 4'd7,  4'd1,  8'h08, 1'b0, 1'b1};
        vecs[14] = '{1'b0, OP_DIV, 4'd15, 4'd15, 8'h01, 1'b0, 1'b0};
        vecs[15] = '{1'b1, OP_MUL, 4'd15, 4'd0,  8'h00, 1'b0, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = 3'd0; req0_a = 4'd0; req0_b = 4'd0;
        req1_valid = 1'b0; req1_op = 3'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        check("rst_rsp_result", {24'd0, rsp_result}, 32'd0);
        check("rst_flags", {30'd0, rsp_carry, rsp_ovf}, 32'd0);
        check("rst_state", {30'd0, fsm_state}, {30'd0, IDLE});
        rst_n = 1'b1;
        tick();

        // Contention from reset: req0 wins first.
        drive_req(1'b0, OP_SUB, 4'd3, 4'd5);
        drive_req(1'b1, OP_MUL, 4'd15, 4'd15);
        #1;
        check("cont_gnt0", {31'd0, req0_ready}, 32'd1);
        check("cont_not1", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) note_accept(1'b0, OP_SUB, 4'd5, 8'h0E, 1'b0, 1'b0);
        tick();
        clear_req(1'b0);
        await_accept(1'b1, OP_MUL, 4'd15, 8'hE1, 1'b0, 1'b0);
        tick();
        clear_req(1'b1);
        // Both valid again after req1 was served: req0 must win.
        drive_req(1'b0, OP_AND, 4'hF, 4'h3);
        drive_req(1'b1, OP_OR, 4'h1, 4'h2);
        n = 0;
        #1;
        while (!(req0_ready || req1_ready) && n < 20) begin
            tick();
            #1;
            n++;
        end
        check("regrant_gnt0", {31'd0, req0_ready}, 32'd1);
        check("regrant_not1", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) note_accept(1'b0, OP_AND, 4'h3, 8'h03, 1'b0, 1'b0);
        tick();
        clear_req(1'b0);
        await_accept(1'b1, OP_OR, 4'h2, 8'h03, 1'b0, 1'b0);
        tick();
        clear_req(1'b1);
        wait_idle("idle_after_cont");
        tick();

        // Single ADD: ready pulses once, response two cycles after accept.
        drive_req(1'b0, OP_ADD, 4'd7, 4'd9);
        #1;
        check("add_ready", {31'd0, req0_ready}, 32'd1);
        if (req0_ready) note_accept(1'b0, OP_ADD, 4'd9, 8'h00, 1'b1, 1'b0);
        tick();
        clear_req(1'b0);
        #1;
        check("add_ready_drop", {31'd0, req0_ready}, 32'd0);
        check("add_exec_state", {30'd0, fsm_state}, {30'd0, EXEC});
        check("add_no_rsp_yet", {31'd0, rsp_valid}, 32'd0);
        check("add_busy", {31'd0, busy}, 32'd1);
        tick();
        #1;
        check("add_latency", {31'd0, rsp_valid}, 32'd1);
        check("add_result", {24'd0, rsp_result}, 32'h00);
        check("add_carry", {31'd0, rsp_carry}, 32'd1);
        check("add_id", {31'd0, rsp_id}, 32'd0);
        tick();
        #1;
        check("add_back_idle", {31'd0, busy}, 32'd0);
        tick();

        // Table vectors, issued back to back.
        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].c, vecs[i].o);
        end

        // Random vectors against the reference model.
        for (int i = 0; i < 24; i++) begin
            rid = 1'($urandom_range(0, 1));
            rop = 3'($urandom_range(0, 7));
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            m = model(rop, ra, rb);
            issue(rid, rop, ra, rb, m[9:2], m[1], m[0]);
        end
        wait_idle("idle_after_rand");
        tick();

        // Backpressure: 5 stalled cycles in RESP.
        rsp_ready = 1'b0;
        issue(1'b0, OP_XOR, 4'hC, 4'hA, 8'h06, 1'b0, 1'b0);
        tick();
        drive_req(1'b1, OP_ADD, 4'd1, 4'd1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_result", {24'd0, rsp_result}, 32'h06);
            check("bp_id", {31'd0, rsp_id}, 32'd0);
            check("bp_ready0", {31'd0, req0_ready}, 32'd0);
            check("bp_ready1", {31'd0, req1_ready}, 32'd0);
            check("bp_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        clear_req(1'b1);
        rsp_ready = 1'b1;
        tick();
        #1;
        check("bp_done_valid", {31'd0, rsp_valid}, 32'd0);
        check("bp_done_busy", {31'd0, busy}, 32'd0);
        tick();

        // Reset mid-EXEC: last served was req0, so only reset makes req0 win next.
        issue(1'b1, OP_ADD, 4'd2, 4'd3, 8'h05, 1'b0, 1'b0);
        rst_n = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        exp_gnt0 = 0; exp_gnt1 = 0; exp_divz = 0;
        #1;
        check("rstx_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rstx_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drive_req(1'b0, OP_NOT, 4'h0, 4'h0);
        drive_req(1'b1, OP_ADD, 4'h1, 4'h1);
        #1;
        check("rstx_gnt0", {31'd0, req0_ready}, 32'd1);
        check("rstx_not1", {31'd0, req1_ready}, 32'd0);
        if (req0_ready) note_accept(1'b0, OP_NOT, 4'h0, 8'h0F, 1'b0, 1'b0);
        tick();
        clear_req(1'b0);
        clear_req(1'b1);
        issue(1'b1, OP_DIV, 4'd7, 4'd0, 8'h00, 1'b0, 1'b0);

        // Drain
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 50) begin
            tick();
            n++;
        end
        check("drain_queue", exp_q.size(), 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);

`ifdef ALU_STATS_EN
        check("stat_gnt0", {24'd0, stat_gnt0}, exp_gnt0);
        check("stat_gnt1", {24'd0, stat_gnt1}, exp_gnt1);
        check("stat_divz", {24'd0, stat_divz}, exp_divz);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
